// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
// Used by uart_rx_fsm and edge_bit_counter.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int BITCNT_W   = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_DEFAULT = 6'd8;

    // Frame-sequencer states. PARITY is only reachable when the parity
    // build option is enabled.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Only 8x, 16x and 32x oversampling are supported; anything else
    // falls back to 8x so the bit timing stays well-defined.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(
        input logic [PRESCALE_W-1:0] p
    );
        if ((p == 6'd8) || (p == 6'd16) || (p == 6'd32)) begin
            return p;
        end
        return PRESCALE_DEFAULT;
    endfunction

    // Oversample edge at which the checkers are enabled: just past mid-bit.
    function automatic logic [PRESCALE_W-1:0] sample_edge(
        input logic [PRESCALE_W-1:0] p
    );
        return (p >> 1) + 6'd2;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver.
// edge_cnt runs 0..prescale_q-1 while enabled; bit_cnt advances on every
// end-of-bit. 'clear' has priority and zeroes both counters.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BITCNT_W-1:0]   bit_cnt,
    output logic                  eob
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [BITCNT_W-1:0]   bit_cnt_q;
    logic [BITCNT_W-1:0]   bit_cnt_d;

    // End-of-bit: last oversample edge of the current bit.
    assign eob = enable && (edge_cnt_q == (prescale_q - 6'd1));

    // Next-count logic: wrap the edge counter at end-of-bit and step the bit index.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clear) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (enable) begin
            if (eob) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: detects the start edge, times each bit via
// edge_bit_counter, enables the sampler/deserializer/checkers and reports
// frame acceptance (data_valid) or rejection (frame_err) as one-cycle pulses.
// Build option: define UART_RX_PARITY_EN to include the PARITY state and honour
// PAR_EN; otherwise frames never carry a parity bit.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] prescale_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BITCNT_W-1:0]   bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
);

    // Bit index of the last data bit (bit 0 is the start bit).
    localparam logic [BITCNT_W-1:0] LAST_DATA_BIT = BITCNT_W'(DATA_WIDTH);

    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [PRESCALE_W-1:0] prescale_d;
    logic                  data_valid_q;
    logic                  data_valid_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    logic                  cnt_enable;
    logic                  cnt_clear;
    logic                  eob;
    logic                  at_sample;
    logic                  frame_bad;

`ifdef UART_RX_PARITY_EN
    logic                  par_en_q;
    logic                  par_en_d;
    logic                  par_err_q;
    logic                  par_err_d;
`else
    // Parity inputs have no function in this build.
    logic                  unused_parity_inputs;
    assign unused_parity_inputs = PAR_EN ^ par_err;
`endif

    // Counters run in every state except IDLE.
    assign cnt_enable = (state_q != IDLE);

    edge_bit_counter u_edge_bit_counter (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (cnt_enable),
        .clear      (cnt_clear),
        .prescale_q (prescale_q),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .eob        (eob)
    );

    assign at_sample = (edge_cnt == sample_edge(prescale_q));

`ifdef UART_RX_PARITY_EN
    assign frame_bad = par_err_q || stp_err;
`else
    assign frame_bad = stp_err;
`endif

    // Next-state, frame-start latching, result pulses and enable decode.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_clear    = 1'b0;
        dat_samp_en  = 1'b0;
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d     = par_en_q;
        par_err_d    = par_err_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
`ifdef UART_RX_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = legal_prescale(Prescale);
`ifdef UART_RX_PARITY_EN
                    par_en_d   = PAR_EN;
`endif
                end
            end

            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = at_sample;
                if (eob) begin
                    if (strt_glitch) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        cnt_clear   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
                if (eob && (bit_cnt == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_chk_en = at_sample;
                if (eob) begin
                    state_d = STOP;
                    if (par_err) begin
                        par_err_d = 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                stp_chk_en = at_sample;
                if (eob) begin
                    cnt_clear = 1'b1;
                    if (frame_bad) begin
                        frame_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                    end
                    if (!RX_IN) begin
                        // Back-to-back frame: start bit already on the line.
                        state_d    = START;
                        prescale_d = legal_prescale(Prescale);
`ifdef UART_RX_PARITY_EN
                        par_en_d   = PAR_EN;
                        par_err_d  = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // State, latched frame configuration and registered result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            prescale_q   <= PRESCALE_DEFAULT;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= par_en_d;
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table of frames plus hand-written
// back-to-back and mid-frame-reset sequences; result pulses are checked
// against a queue of expected {kind, cycle} entries.
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int DW = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] prescale_q;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .prescale_q  (prescale_q),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] prescale;
        bit         par_en;
        logic [7:0] data;
        bit         glitch;
        bit         par_bad;
        bit         stop_bad;
        bit         exp_valid;
        bit         exp_ferr;
    } vec_t;

    typedef struct {
        bit valid;
        bit ferr;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int deser_cnt = 0;
    int strt_cnt = 0;
    int par_cnt = 0;
    int stp_cnt = 0;
    int cur_s = 6;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: count enables, check checker-enable timing, score result pulses.
    always @(negedge CLK) begin
        if (deser_en) deser_cnt++;
        if (strt_chk_en) strt_cnt++;
        if (par_chk_en) par_cnt++;
        if (stp_chk_en) stp_cnt++;
        if (strt_chk_en || par_chk_en || stp_chk_en) begin
            checks++;
            if (int'(edge_cnt) != cur_s) begin
                errors++;
                $display("FAIL chk_edge: edge_cnt=%0d required %0d", edge_cnt, cur_s);
            end
        end
        if (par_chk_en) begin
            checks++;
            if (int'(bit_cnt) != DW + 1) begin
                errors++;
                $display("FAIL par_bit: bit_cnt=%0d required %0d", bit_cnt, DW + 1);
            end
        end
        if (data_valid || frame_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: valid=%0b ferr=%0b at cycle %0d, none required",
                         data_valid, frame_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (data_valid !== mon_e.valid || frame_err !== mon_e.ferr || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL pulse: valid=%0b ferr=%0b cycle=%0d required valid=%0b ferr=%0b cycle=%0d",
                             data_valid, frame_err, cyc, mon_e.valid, mon_e.ferr, mon_e.due);
                end else begin
                    $display("pulse ok: valid=%0b ferr=%0b cycle=%0d", data_valid, frame_err, cyc);
                end
            end
        end
    end

    // Drive one frame on RX_IN (and the checker results) and schedule its expected pulse.
    task automatic send_frame(input vec_t v, input bit no_idle);
        logic [5:0]  p_eff;
        bit          par_eff;
        int          nbits;
        int          len;
        int          n0;
        logic [10:0] bits;
        p_eff   = (v.prescale == 6'd8 || v.prescale == 6'd16 || v.prescale == 6'd32) ? v.prescale : 6'd8;
        par_eff = PAR_BUILD && v.par_en;
        nbits   = 10 + (par_eff ? 1 : 0);
        len     = v.glitch ? int'(p_eff) : int'(p_eff) * nbits;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = v.data;
        if (par_eff) bits[9] = ^v.data;
        bits[nbits-1] = !v.stop_bad;

        Prescale    = v.prescale;
        PAR_EN      = v.par_en;
        strt_glitch = v.glitch;
        par_err     = v.par_bad;
        stp_err     = v.stop_bad;
        deser_cnt = 0; strt_cnt = 0; par_cnt = 0; stp_cnt = 0;
        cur_s = int'(p_eff) / 2 + 2;
        n0 = cyc;
        sb.push_back('{valid: v.exp_valid, ferr: v.exp_ferr, due: n0 + 1 + len});

        for (int c = 0; c < len; c++) begin
            if (v.glitch) RX_IN = (c < 3) ? 1'b0 : 1'b1;
            else          RX_IN = bits[c / int'(p_eff)];
            @(posedge CLK); #1;
            if (c == 0) begin
                checks++;
                if (!(prescale_q == p_eff && edge_cnt == 6'd0 && bit_cnt == 4'd0 && dat_samp_en)) begin
                    errors++;
                    $display("FAIL start_entry: prescale_q=%0d edge=%0d bit=%0d samp=%0b required %0d/0/0/1",
                             prescale_q, edge_cnt, bit_cnt, dat_samp_en, p_eff);
                end
            end
            if (c == 2) begin
                // Mid-frame config changes must not affect the running frame.
                Prescale = (p_eff == 6'd32) ? 6'd16 : 6'd32;
                PAR_EN   = !v.par_en;
            end
        end

        if (!no_idle) begin
            RX_IN = 1'b1;
            @(posedge CLK); #1;
            strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
            repeat (3) @(posedge CLK);
            #1;
            checks++;
            if (deser_cnt != (v.glitch ? 0 : DW * int'(p_eff))) begin
                errors++;
                $display("FAIL deser_cycles: %0d required %0d", deser_cnt, v.glitch ? 0 : DW * int'(p_eff));
            end
            checks++;
            if (strt_cnt != 1 || stp_cnt != (v.glitch ? 0 : 1) || par_cnt != ((par_eff && !v.glitch) ? 1 : 0)) begin
                errors++;
                $display("FAIL chk_counts: strt=%0d par=%0d stp=%0d required 1/%0d/%0d",
                         strt_cnt, par_cnt, stp_cnt, (par_eff && !v.glitch) ? 1 : 0, v.glitch ? 0 : 1);
            end
            checks++;
            if (dat_samp_en || edge_cnt != 6'd0 || bit_cnt != 4'd0) begin
                errors++;
                $display("FAIL back_to_idle: samp=%0b edge=%0d bit=%0d required 0/0/0",
                         dat_samp_en, edge_cnt, bit_cnt);
            end
            $display("frame P=%0d par_en=%0b data=%02h glitch=%0b par_bad=%0b stop_bad=%0b len=%0d",
                     v.prescale, v.par_en, v.data, v.glitch, v.par_bad, v.stop_bad, len);
        end
    endtask

    // Collapse every design output except prescale_q into one word for reset checks.
    function automatic logic [16:0] outs_word();
        return {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                data_valid, frame_err, edge_cnt, bit_cnt};
    endfunction

    initial begin
        vec_t b2b;
        vecs[0] = '{6'd8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{6'd8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{6'd32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{6'd16, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, !PAR_BUILD, PAR_BUILD};
        vecs[5] = '{6'd20, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{6'd32, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{6'd8,  1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd32;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (outs_word() != '0 || prescale_q != 6'd8) begin
            errors++;
            $display("FAIL reset_state: outs=%h prescale_q=%0d required 0 and 8", outs_word(), prescale_q);
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i], 1'b0);
            repeat (4) @(posedge CLK);
            #1;
        end

        // Back-to-back frames: second start bit sampled on the first STOP end-of-bit.
        b2b = '{6'd8, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        send_frame(b2b, 1'b1);
        b2b.data = 8'h96;
        send_frame(b2b, 1'b0);
        $display("back-to-back pair sent");
        repeat (4) @(posedge CLK);
        #1;

        // Reset during bit 4 of a frame, with Prescale changed mid-frame.
        Prescale = 6'd8; PAR_EN = 1'b0; cur_s = 6;
        RX_IN = 1'b0;
        repeat (36) @(posedge CLK);
        #1;
        checks++;
        if (bit_cnt != 4'd4 || edge_cnt != 6'd3 || !deser_en) begin
            errors++;
            $display("FAIL mid_frame: bit=%0d edge=%0d deser=%0b required 4/3/1", bit_cnt, edge_cnt, deser_en);
        end
        Prescale = 6'd16;
        RX_IN = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (prescale_q != 6'd8) begin
            errors++;
            $display("FAIL prescale_hold: prescale_q=%0d required 8", prescale_q);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (outs_word() != '0 || prescale_q != 6'd8) begin
            errors++;
            $display("FAIL async_reset: outs=%h prescale_q=%0d required 0 and 8", outs_word(), prescale_q);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (outs_word() != '0) begin
            errors++;
            $display("FAIL reset_hold: outs=%h required 0", outs_word());
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        $display("mid-frame reset applied");
        b2b = '{6'd16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        send_frame(b2b, 1'b0);

        repeat (10) @(posedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pulse_timeout: %0d expected pulses never seen", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-sequencing controller for the UART receiver. Detects the start edge on `RX_IN` and times every bit with an oversampling edge counter and a bit counter. Drives the enables of the sampler, deserializer and start/parity/stop checkers, and issues a one-cycle `data_valid` when a clean frame completes. Sits between the RX pin synchroniser and the RX datapath (sampler, deserializer, checkers).

## Interface
- `DATA_WIDTH`, 8, data bits per frame; range 5–8.
- `CLK`  in  1  oversampling clock.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  synchronised serial line; idles high.
- `PAR_EN`  in  1  parity bit present in the frame.
- `Prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32.
- `strt_glitch`  in  1  start-bit sample was 1 (from the start checker).
- `par_err`  in  1  parity mismatch (from the parity checker).
- `stp_err`  in  1  stop-bit sample was 0 (from the stop checker).
- `prescale_q`  out  6  Prescale latched for the current frame; feeds the sampler and deserializer.
- `edge_cnt`  out  6  oversample edge index within the current bit, 0..prescale_q-1.
- `bit_cnt`  out  4  bit index within the frame; 0 = start bit.
- `dat_samp_en`  out  1  sampler enable.
- `deser_en`  out  1  deserializer enable.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each  checker enables.
- `data_valid`  out  1  one-cycle pulse: frame accepted.
- `frame_err`  out  1  one-cycle pulse: frame dropped.

All outputs reset to 0. `prescale_q` resets to 8.

## Operation
Definitions:
- S = `prescale_q >> 1` + 2. This is the sample-decision edge.
- End-of-bit (EOB) = `edge_cnt == prescale_q - 1`.

States and transitions:
- **IDLE**
  - All enables are 0; `edge_cnt` = 0; `bit_cnt` = 0.
  - `RX_IN == 0` → START. On the same edge, latch `prescale_q <= Prescale`.
- **START**
  - `dat_samp_en` = 1. `strt_chk_en` = 1 only while `edge_cnt == S`.
  - At EOB: if `strt_glitch` → IDLE with a `frame_err` pulse.
  - Otherwise → DATA with `bit_cnt` = 1.
- **DATA**
  - `dat_samp_en` = 1 and `deser_en` = 1.
  - At EOB, `bit_cnt` increments.
  - At EOB with `bit_cnt == DATA_WIDTH`: go to PARITY if `PAR_EN`, else STOP.
- **PARITY**
  - `par_chk_en` = 1 at `edge_cnt == S`.
  - At EOB → STOP unconditionally. `par_err` is sticky-latched for the rest of the frame.
- **STOP**
  - `stp_chk_en` = 1 at `edge_cnt == S`.
  - At EOB: if neither the latched parity error nor `stp_err` is set, pulse `data_valid`; otherwise pulse `frame_err`.
  - Next state: START if `RX_IN == 0` on that edge (back-to-back frame; Prescale re-latched), else IDLE.

Rules:
- `edge_cnt` wraps to 0 at EOB and increments every cycle in every non-IDLE state.
- `bit_cnt` clears to 0 on entry to IDLE or START.
- `PAR_EN` and `Prescale` are read only at frame start. Changes mid-frame take effect on the next frame.
- A `Prescale` value other than 8, 16 or 32 is latched as 8.

## Timing
- The first START cycle follows the falling edge detected in IDLE. That cycle has `edge_cnt` = 0.
- Frame length in cycles: `prescale_q` × (2 + DATA_WIDTH + PAR_EN).
- `data_valid` and `frame_err` are registered, one cycle wide, and asserted on the cycle after the STOP EOB. They are never both high.
- Checker inputs are sampled at EOB. Checkers must present results by S+1.
- If `RST` is asserted mid-frame, all state clears immediately, no pulse is issued, and the block restarts in IDLE.

## Configuration
Macro: `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state exists and `PAR_EN` is honoured.
- **Undefined:** the PARITY state is not compiled, `PAR_EN` is ignored, `par_chk_en` is tied to 0, and the parity-error latch is removed. DATA always goes to STOP.
- The port list is identical in both builds.

## Structure
- Package `uart_rx_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `PRESCALE_W` = 6 and `BITCNT_W` = 4;
  - `PRESCALE_DEFAULT` = 8.
- Sub-module `edge_bit_counter`:
  - inputs: `CLK`, `RST`, `enable`, `clear`, `prescale_q`;
  - outputs: `edge_cnt`, `bit_cnt`, and an `eob` strobe.
- The FSM, enable decode and error latch stay in `uart_rx_fsm`.

## Test plan
- Prescale=8, PAR_EN=0, byte 0xA5 sent LSB-first → `deser_en` high for 64 cycles; `data_valid` 1 cycle, 80 cycles after the start edge; `frame_err` = 0.
- Prescale=16, PAR_EN=1, 0x3C with correct even parity → frame of 176 cycles; `par_chk_en` pulses at `edge_cnt` = 10 of bit 9; `data_valid` = 1.
- RX_IN low for 3 cycles then high (`strt_glitch` = 1 at EOB) → return to IDLE after 8 cycles; one `frame_err` pulse; `deser_en` never asserted.
- Stop bit driven 0 (`stp_err` = 1), Prescale=32 → `frame_err` pulse; no `data_valid`.
- Two back-to-back frames with no idle gap → second START entered directly from STOP; two `data_valid` pulses exactly 80 cycles apart (Prescale=8).
- RST low at bit 4 of a frame, Prescale changed 8→16 mid-frame → all outputs 0 during reset; next frame uses 16; `bit_cnt` restarts at 0.
